// File: rtl/freq_gen_pkg.sv
// Shared definitions for the multi-channel frequency generator: default
// counter width, the shortest period that still toggles, the configuration
// record and the per-channel run state.
package freq_gen_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int MIN_PERIOD = 2;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] high;
  } cfg_t;

  // A channel is either idle (counter parked at 0, outputs low) or running.
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  // Width of a channel index; a single channel still needs one select bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/freq_gen_ch.sv
// One generator channel: shadow configuration with pending flag, active
// period/high registers, a wrap-around counter and registered clk_out/tick.
// Shadow values move into the active registers only at a period boundary,
// or at the next edge when the channel is idle, so the waveform never glitches.
module freq_gen_ch
  import freq_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             en,
  output logic             clk_out,
  output logic             tick,
  output logic             pending,
  output ch_state_t        state
);

  ch_state_t        state_n;
  logic [CNT_W-1:0] per_a, per_a_n;
  logic [CNT_W-1:0] high_a, high_a_n;
  logic [CNT_W-1:0] per_s, per_s_n;
  logic [CNT_W-1:0] high_s, high_s_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             pend, pend_n;
  logic             clk_q, clk_n;
  logic             tick_q, tick_n;
  logic             run_now;
  logic             wrap;
  logic             apply;

  assign cnt_inc = cnt + CNT_W'(1);

  // Next-state: decide idle/start/advance/boundary, then fold in shadow
  // application and a new write (a write always wins the pend flag).
  always_comb begin
    state_n  = CH_IDLE;
    per_a_n  = per_a;
    high_a_n = high_a;
    per_s_n  = per_s;
    high_s_n = high_s;
    pend_n   = pend;
    cnt_n    = '0;
    clk_n    = 1'b0;
    tick_n   = 1'b0;
    apply    = 1'b0;
    run_now  = en && (per_a >= CNT_W'(MIN_PERIOD));
    wrap     = (cnt >= (per_a - CNT_W'(1)));

    if (!run_now) begin
      // No boundary will ever come while idle, so take the shadow right away.
      apply = pend;
    end else if (state == CH_IDLE) begin
      // First running cycle: counter position 0.
      state_n = CH_RUN;
      tick_n  = 1'b1;
      clk_n   = (high_a != '0);
    end else if (wrap) begin
      apply = pend;
      if (pend) begin
        // The incoming period may itself be too short to run.
        if (per_s >= CNT_W'(MIN_PERIOD)) begin
          state_n = CH_RUN;
          tick_n  = 1'b1;
          clk_n   = (high_s != '0);
        end
      end else begin
        state_n = CH_RUN;
        tick_n  = 1'b1;
        clk_n   = (high_a != '0);
      end
    end else begin
      state_n = CH_RUN;
      cnt_n   = cnt_inc;
      clk_n   = (cnt_inc < high_a);
    end

    if (apply) begin
      per_a_n  = per_s;
      high_a_n = high_s;
      pend_n   = 1'b0;
    end

    if (wr) begin
      per_s_n  = cfg_period;
      high_s_n = cfg_high;
      pend_n   = 1'b1;
    end
  end

  // State and output registers; reset parks the channel fully unconfigured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CH_IDLE;
      per_a  <= '0;
      high_a <= '0;
      per_s  <= '0;
      high_s <= '0;
      pend   <= 1'b0;
      cnt    <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      state  <= state_n;
      per_a  <= per_a_n;
      high_a <= high_a_n;
      per_s  <= per_s_n;
      high_s <= high_s_n;
      pend   <= pend_n;
      cnt    <= cnt_n;
      clk_q  <= clk_n;
      tick_q <= tick_n;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend;

endmodule

// File: rtl/freq_gen_multi.sv
// Multi-channel frequency generator top: decodes the shared configuration
// port into per-channel write strobes and instantiates one freq_gen_ch per
// channel. Writes addressed beyond the last channel match no strobe.
module freq_gen_multi
  import freq_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] ch_running
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic      wr;
    ch_state_t st;

    assign wr            = cfg_we && (cfg_ch == CH_W'(i));
    assign ch_running[i] = (st == CH_RUN);

    freq_gen_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr         (wr),
      .cfg_period (cfg_period),
      .cfg_high   (cfg_high),
      .en         (ch_en[i]),
      .clk_out    (clk_out[i]),
      .tick       (tick[i]),
      .pending    (pending[i]),
      .state      (st)
    );
  end

endmodule

// File: tb/tb_freq_gen_multi.sv
// Directed bench for freq_gen_multi with three channels: a per-cycle vector
// table on channel 0, a long 750-cycle period measurement on channel 1, and
// an asynchronous reset abort followed by reprogramming.
module tb_freq_gen_multi;
  import freq_gen_pkg::*;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_period;
  logic [CW-1:0]  cfg_high;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] ch_running;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [NCH-1:0] en;
    logic           we;
    logic [CHW-1:0] ch;
    cfg_t           cfg;
    logic [NCH-1:0] e_clk;
    logic [NCH-1:0] e_tick;
    logic [NCH-1:0] e_pend;
  } vec_t;

  vec_t vt[$];

  // clock / reset
  always #5 clk = ~clk;

  freq_gen_multi #(
    .NUM_CH (NCH),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .ch_en      (ch_en),
    .clk_out    (clk_out),
    .tick       (tick),
    .pending    (pending),
    .ch_running (ch_running)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int per, input int high);
    cfg_we     = 1'b1;
    cfg_ch     = CHW'(ch);
    cfg_period = CW'(per);
    cfg_high   = CW'(high);
    step();
    cfg_we     = 1'b0;
  endtask

  task automatic add(input int en, input int we, input int ch, input int per, input int high,
                     input int eclk, input int etick, input int epend);
    vec_t v;
    v.en         = NCH'(en);
    v.we         = (we != 0);
    v.ch         = CHW'(ch);
    v.cfg.period = CW'(per);
    v.cfg.high   = CW'(high);
    v.e_clk      = NCH'(eclk);
    v.e_tick     = NCH'(etick);
    v.e_pend     = NCH'(epend);
    vt.push_back(v);
  endtask

  int ticks;
  int highs;
  int last_tick;
  int bad_gap;

  initial begin
    rst_n      = 1'b0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    cfg_high   = '0;
    ch_en      = '0;

    // Channel 0 cycle table: inputs before the edge, outputs after it.
    //   en we ch per high  clk tick pend
    add(0, 1, 0, 4, 2,   0, 0, 1);  // write while idle
    add(0, 0, 0, 0, 0,   0, 0, 0);  // idle edge applies shadow
    add(1, 0, 0, 0, 0,   1, 1, 0);  // enable: cnt0
    add(1, 0, 0, 0, 0,   1, 0, 0);  // cnt1
    add(1, 0, 0, 0, 0,   0, 0, 0);  // cnt2
    add(1, 0, 0, 0, 0,   0, 0, 0);  // cnt3
    add(1, 0, 0, 0, 0,   1, 1, 0);  // cnt0
    add(1, 0, 0, 0, 0,   1, 0, 0);  // cnt1
    add(1, 1, 0, 6, 1,   0, 0, 1);  // write at cnt1 -> cnt2
    add(1, 0, 0, 0, 0,   0, 0, 1);  // cnt3, old period completes
    add(1, 0, 0, 0, 0,   1, 1, 0);  // boundary: 6/1 applied
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 0);  // cnt1..5
    add(1, 0, 0, 0, 0,   1, 1, 0);  // cnt0
    add(1, 1, 0, 5, 0,   0, 0, 1);  // cnt1, shadow 5/0
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 0, 0, 1);  // cnt2..5
    add(1, 0, 0, 0, 0,   0, 1, 0);  // high=0: tick but no high
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0);  // cnt1..3
    add(1, 1, 0, 5, 9,   0, 0, 1);  // cnt4, shadow 5/9
    add(1, 1, 0, 7, 3,   1, 1, 1);  // boundary + write: 5/9 applied, 7/3 pending
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 1, 0, 1);  // saturated high
    add(1, 0, 0, 0, 0,   1, 1, 0);  // boundary: 7/3 applied
    add(1, 0, 0, 0, 0,   1, 0, 0);  // cnt1
    add(1, 0, 0, 0, 0,   1, 0, 0);  // cnt2
    add(1, 1, 3, 4, 4,   0, 0, 0);  // cnt3, write to ch3 ignored
    add(1, 1, 0, 8, 8,   0, 0, 1);  // cnt4, first of double write
    add(1, 1, 0, 4, 1,   0, 0, 1);  // cnt5, second write wins
    add(1, 0, 0, 0, 0,   0, 0, 1);  // cnt6
    add(1, 0, 0, 0, 0,   1, 1, 0);  // boundary: 4/1 applied
    add(1, 0, 0, 0, 0,   0, 0, 0);  // cnt1
    add(1, 0, 0, 0, 0,   0, 0, 0);  // cnt2
    add(1, 0, 0, 0, 0,   0, 0, 0);  // cnt3
    add(1, 0, 0, 0, 0,   1, 1, 0);  // cnt0
    add(1, 0, 0, 0, 0,   0, 0, 0);  // cnt1
    add(0, 0, 0, 0, 0,   0, 0, 0);  // enable fall mid-period
    add(1, 0, 0, 0, 0,   1, 1, 0);  // restart at cnt0
    add(1, 0, 0, 0, 0,   0, 0, 0);  // cnt1
    add(1, 1, 0, 1, 1,   0, 0, 1);  // cnt2, shadow period 1
    add(1, 0, 0, 0, 0,   0, 0, 1);  // cnt3
    add(1, 0, 0, 0, 0,   0, 0, 0);  // boundary: period 1 -> idle
    add(1, 0, 0, 0, 0,   0, 0, 0);  // stays idle
    add(1, 1, 0, 0, 0,   0, 0, 1);  // period 0 written
    add(1, 0, 0, 0, 0,   0, 0, 0);  // applied while idle
    add(1, 0, 0, 0, 0,   0, 0, 0);  // still idle

    // Reset state, checked while reset is held.
    #12;
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick",    32'(tick),    32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table-driven section on channel 0.
    foreach (vt[k]) begin
      ch_en      = vt[k].en;
      cfg_we     = vt[k].we;
      cfg_ch     = vt[k].ch;
      cfg_period = vt[k].cfg.period;
      cfg_high   = vt[k].cfg.high;
      step();
      cfg_we = 1'b0;
      check($sformatf("vec%0d_clk", k),  32'(clk_out), 32'(vt[k].e_clk));
      check($sformatf("vec%0d_tick", k), 32'(tick),    32'(vt[k].e_tick));
      check($sformatf("vec%0d_pend", k), 32'(pending), 32'(vt[k].e_pend));
    end

    // Channel 1: period 750, high 375, 100 periods in 75000 cycles.
    ch_en = 3'b000;
    cfg_write(1, 750, 375);
    check("ch1_pend_set", 32'(pending), 32'b010);
    step();
    check("ch1_pend_clr", 32'(pending), 32'b000);
    ch_en = 3'b010;
    step();
    check("ch1_first_tick", 32'(tick),    32'b010);
    check("ch1_first_clk",  32'(clk_out), 32'b010);
    ticks     = 0;
    highs     = 0;
    last_tick = 0;
    bad_gap   = 0;
    for (int i = 0; i < 75000; i++) begin
      if (tick[1]) begin
        if (ticks > 0 && (i - last_tick) != 750) bad_gap++;
        last_tick = i;
        ticks++;
      end
      if (clk_out[1]) highs++;
      step();
    end
    check("ch1_ticks",     32'(ticks),   32'd100);
    check("ch1_highs",     32'(highs),   32'd37500);
    check("ch1_gap_errs",  32'(bad_gap), 32'd0);
    check("ch1_tick_101",  32'(tick),    32'b010);

    // Asynchronous reset mid-period with a pending write on channel 2.
    cfg_write(2, 10, 5);
    check("pre_rst_pend", 32'(pending), 32'b100);
    check("pre_rst_clk1", 32'(clk_out), 32'b010);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_clk",  32'(clk_out), 32'd0);
    check("async_rst_tick", 32'(tick),    32'd0);
    check("async_rst_pend", 32'(pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ch_en = 3'b111;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("post_rst_idle%0d", i), 32'({clk_out, tick}), 32'd0);
    end

    // Reprogram channel 1 after reset: period 3, high 1.
    cfg_write(1, 3, 1);
    check("re_pend_set", 32'(pending), 32'b010);
    step();
    check("re_pend_clr", 32'(pending), 32'b000);
    check("re_idle_clk", 32'(clk_out), 32'b000);
    step();
    check("re_start_tick", 32'(tick),    32'b010);
    check("re_start_clk",  32'(clk_out), 32'b010);
    step();
    check("re_cnt1_clk",   32'(clk_out), 32'b000);
    step();
    check("re_cnt2_tick",  32'(tick),    32'b000);
    step();
    check("re_wrap_tick",  32'(tick),    32'b010);
    check("re_wrap_clk",   32'(clk_out), 32'b010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
